// File: rtl/busca_instrucao_if.sv
// Signal bundle between the fetch sequencer, the instruction ROM and the control decoder.
// The master side is the fetch unit; the slave side is the ROM/decoder/control environment.
interface busca_instrucao_if #(
  parameter int ADDR_W = 8
);
  logic              _start;
  logic              _stall;
  logic              _imem_req;
  logic [ADDR_W-1:0] _imem_addr;
  logic [31:0]       _imem_data;
  logic [31:0]       _instrucao;
  logic              _inst_valid;
  logic [ADDR_W-1:0] _pc;
  logic              _busy;
  logic              _halted;

  modport master (
    input  _start, _stall, _imem_data,
    output _imem_req, _imem_addr, _instrucao, _inst_valid, _pc, _busy, _halted
  );

  modport slave (
    output _start, _stall, _imem_data,
    input  _imem_req, _imem_addr, _instrucao, _inst_valid, _pc, _busy, _halted
  );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch sequencer: one ROM read per instruction, issue under a valid/stall
// handshake, stop on the HALT opcode until the next start pulse.
module busca_instrucao #(
  parameter int ADDR_W   = 8,
  parameter int MEM_LAT  = 1,
  parameter int RESET_PC = 0
) (
  input  logic               _clock,
  input  logic               _reset_n,
  busca_instrucao_if.master  bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, ISSUE, HALT} state_t;

  localparam logic [2:0]        OP_HALT   = 3'b101;
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
  localparam logic [1:0]        WAIT_INIT = 2'(MEM_LAT - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        wait_cnt;
  logic [31:0]       instrucao;
  logic              inst_valid;
  logic [ADDR_W-1:0] pc_issued;

  logic word_ready;
  logic word_is_halt;
  logic start_ok;
  logic consume;

  assign word_ready   = (state == WAIT) && (wait_cnt == 2'd0);
  assign word_is_halt = bus._imem_data[31:29] == OP_HALT;
  assign start_ok     = ((state == IDLE) || (state == HALT)) && bus._start;
  assign consume      = (state == ISSUE) && !bus._stall;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, HALT: if (bus._start) state_next = REQ;
      REQ:        state_next = WAIT;
      WAIT:       if (wait_cnt == 2'd0) state_next = word_is_halt ? HALT : ISSUE;
      ISSUE:      if (!bus._stall) state_next = REQ;
      default:    state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      pc         <= PC_INIT;
      wait_cnt   <= 2'd0;
      instrucao  <= 32'h0;
      inst_valid <= 1'b0;
      pc_issued  <= PC_INIT;
    end else begin
      if (start_ok) pc <= PC_INIT;

      if (state == REQ)                         wait_cnt <= WAIT_INIT;
      else if (state == WAIT && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;

      // A HALT word only moves _pc; the decoder never sees it as a live instruction.
      if (word_ready) begin
        pc_issued <= pc;
        if (!word_is_halt) begin
          instrucao  <= bus._imem_data;
          inst_valid <= 1'b1;
        end
      end

      if (consume) begin
        inst_valid <= 1'b0;
        pc         <= pc + ADDR_W'(1);
      end
    end
  end

  assign bus._imem_req   = (state == REQ);
  assign bus._imem_addr  = pc;
  assign bus._instrucao  = instrucao;
  assign bus._inst_valid = inst_valid;
  assign bus._pc         = pc_issued;
  assign bus._busy       = (state == REQ) || (state == WAIT) || (state == ISSUE);
  assign bus._halted     = (state == HALT);
endmodule

// File: tb/tb_busca_instrucao.sv
// Three fetch units of different geometry, each fed by a latency-accurate ROM, checked every
// cycle against a timeline model: request, capture, issue window, consume, halt.
module tb_busca_instrucao;
  localparam int AW  [3] = '{8, 2, 8};
  localparam int LAT [3] = '{1, 2, 4};
  localparam int RPC [3] = '{0, 3, 16};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  busca_instrucao_if #(.ADDR_W(AW[0])) bus0 ();
  busca_instrucao_if #(.ADDR_W(AW[1])) bus1 ();
  busca_instrucao_if #(.ADDR_W(AW[2])) bus2 ();

  busca_instrucao #(.ADDR_W(AW[0]), .MEM_LAT(LAT[0]), .RESET_PC(RPC[0])) dut0 (
    ._clock(clk), ._reset_n(rst_n), .bus(bus0));
  busca_instrucao #(.ADDR_W(AW[1]), .MEM_LAT(LAT[1]), .RESET_PC(RPC[1])) dut1 (
    ._clock(clk), ._reset_n(rst_n), .bus(bus1));
  busca_instrucao #(.ADDR_W(AW[2]), .MEM_LAT(LAT[2]), .RESET_PC(RPC[2])) dut2 (
    ._clock(clk), ._reset_n(rst_n), .bus(bus2));

  logic        start_d [3];
  logic        stall_d [3];
  logic [31:0] rdata   [3];
  logic        m_req [3], m_valid [3], m_busy [3], m_halted [3];
  logic [7:0]  m_addr [3], m_pc [3];
  logic [31:0] m_instr [3];

  assign bus0._start = start_d[0];  assign bus0._stall = stall_d[0];  assign bus0._imem_data = rdata[0];
  assign bus1._start = start_d[1];  assign bus1._stall = stall_d[1];  assign bus1._imem_data = rdata[1];
  assign bus2._start = start_d[2];  assign bus2._stall = stall_d[2];  assign bus2._imem_data = rdata[2];

  assign m_req[0] = bus0._imem_req;  assign m_valid[0] = bus0._inst_valid;  assign m_busy[0] = bus0._busy;
  assign m_req[1] = bus1._imem_req;  assign m_valid[1] = bus1._inst_valid;  assign m_busy[1] = bus1._busy;
  assign m_req[2] = bus2._imem_req;  assign m_valid[2] = bus2._inst_valid;  assign m_busy[2] = bus2._busy;
  assign m_halted[0] = bus0._halted;  assign m_instr[0] = bus0._instrucao;
  assign m_halted[1] = bus1._halted;  assign m_instr[1] = bus1._instrucao;
  assign m_halted[2] = bus2._halted;  assign m_instr[2] = bus2._instrucao;
  assign m_addr[0] = bus0._imem_addr;  assign m_pc[0] = bus0._pc;
  assign m_addr[1] = {6'b0, bus1._imem_addr};  assign m_pc[1] = {6'b0, bus1._pc};
  assign m_addr[2] = bus2._imem_addr;  assign m_pc[2] = bus2._pc;

  // ROM: the word requested in cycle t is on the data bus only during cycle t+LAT; junk otherwise.
  logic [31:0] rom    [3][256];
  logic [7:0]  pipe_a [3][4];
  logic        pipe_v [3][4];
  logic [31:0] junk   [3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      pipe_a[d][0] <= m_addr[d];
      pipe_v[d][0] <= m_req[d];
      for (int s = 1; s < 4; s++) begin
        pipe_a[d][s] <= pipe_a[d][s-1];
        pipe_v[d][s] <= pipe_v[d][s-1];
      end
      junk[d] <= $urandom;
    end
  end

  always_comb begin
    for (int d = 0; d < 3; d++)
      rdata[d] = (pipe_v[d][LAT[d]-1] === 1'b1) ? rom[d][pipe_a[d][LAT[d]-1]] : junk[d];
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_instr [3];
  logic [7:0]  exp_pc    [3];
  int          req_log  [$];
  logic [7:0]  addr_log [$];
  int          first_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_d[d] = 1'b0;
      stall_d[d] = 1'b0;
      exp_instr[d] = 32'h0;
      exp_pc[d] = 8'(RPC[d]);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fill_rom(input int d, input int halt_off);
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w[31:29] == 3'b101) w[31] = 1'b0;
      rom[d][i] = w;
    end
    if (halt_off >= 0) rom[d][(RPC[d] + halt_off) % (1 << AW[d])] = {3'b101, 29'($urandom)};
  endtask

  // Start pulse in cycle 0, then per cycle: request at r, capture at r+LAT, valid from r+LAT+1
  // until the first unstalled cycle c, next request at c+1; a HALT word halts from r+LAT+1.
  task automatic run_prog(input int d, input int max_cyc, input int pct, input bit from_halt,
                          input bit noise, input int st_lo, input int st_hi);
    int          r, v, lat, mask;
    logic [7:0]  a;
    logic [31:0] w;
    bit          hl, st, e_req, e_valid, e_busy, e_halt;
    lat = LAT[d];
    mask = (1 << AW[d]) - 1;
    a = 8'(RPC[d]);
    r = 1;
    v = lat + 2;
    hl = 1'b0;
    req_log.delete();
    addr_log.delete();
    first_valid = -1;
    for (int k = 0; k < max_cyc; k++) begin
      e_req   = k > 0 && !hl && k == r;
      e_valid = k > 0 && !hl && k >= v;
      e_busy  = k > 0 && !hl;
      e_halt  = (k == 0) ? from_halt : hl;
      n_cmp += 6;
      if (m_req[d] !== e_req) begin n_bad++;
        $display("FAIL req d%0d k%0d: got %b want %b", d, k, m_req[d], e_req); end
      if (m_valid[d] !== e_valid) begin n_bad++;
        $display("FAIL inst_valid d%0d k%0d: got %b want %b", d, k, m_valid[d], e_valid); end
      if (m_busy[d] !== e_busy) begin n_bad++;
        $display("FAIL busy d%0d k%0d: got %b want %b", d, k, m_busy[d], e_busy); end
      if (m_halted[d] !== e_halt) begin n_bad++;
        $display("FAIL halted d%0d k%0d: got %b want %b", d, k, m_halted[d], e_halt); end
      if (m_pc[d] !== exp_pc[d]) begin n_bad++;
        $display("FAIL pc d%0d k%0d: got %0h want %0h", d, k, m_pc[d], exp_pc[d]); end
      if (m_instr[d] !== exp_instr[d]) begin n_bad++;
        $display("FAIL instrucao d%0d k%0d: got %h want %h", d, k, m_instr[d], exp_instr[d]); end
      if (e_req) begin
        n_cmp++;
        if (m_addr[d] !== a) begin n_bad++;
          $display("FAIL imem_addr d%0d k%0d: got %0h want %0h", d, k, m_addr[d], a); end
      end
      if (m_req[d] === 1'b1) begin req_log.push_back(k); addr_log.push_back(m_addr[d]); end
      if (m_valid[d] === 1'b1 && first_valid < 0) first_valid = k;
      if (hl && k >= r + lat + 2) break;

      if (k > 0 && !hl && k == r + lat) begin
        w = rom[d][a];
        exp_pc[d] = a;
        if (w[31:29] == 3'b101) hl = 1'b1;
        else exp_instr[d] = w;
      end
      st = (k >= st_lo && k <= st_hi) || ($urandom_range(0, 99) < pct);
      stall_d[d] = st;
      start_d[d] = (k == 0) || (noise && k > 0 && !hl && $urandom_range(0, 7) == 0);
      if (k > 0 && !hl && k >= v && !st) begin
        a = 8'((a + 1) & mask);
        r = k + 1;
        v = r + lat + 1;
      end
      tick();
    end
    start_d[d] = 1'b0;
    stall_d[d] = 1'b0;
  endtask

  task automatic test_reset(input bit mid_wait);
    if (mid_wait) begin
      start_d[2] = 1'b1;
      tick();
      start_d[2] = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (m_busy[2] !== 1'b1) begin n_bad++;
        $display("FAIL busy_before_reset: got %b want 1", m_busy[2]); end
    end else begin
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp += 7;
      if (m_req[d] !== 1'b0) begin n_bad++; $display("FAIL rst_req d%0d: got %b want 0", d, m_req[d]); end
      if (m_addr[d] !== 8'(RPC[d])) begin n_bad++;
        $display("FAIL rst_addr d%0d: got %0h want %0h", d, m_addr[d], RPC[d]); end
      if (m_pc[d] !== 8'(RPC[d])) begin n_bad++;
        $display("FAIL rst_pc d%0d: got %0h want %0h", d, m_pc[d], RPC[d]); end
      if (m_instr[d] !== 32'h0) begin n_bad++;
        $display("FAIL rst_instrucao d%0d: got %h want 0", d, m_instr[d]); end
      if (m_valid[d] !== 1'b0) begin n_bad++; $display("FAIL rst_valid d%0d: got %b want 0", d, m_valid[d]); end
      if (m_busy[d] !== 1'b0) begin n_bad++; $display("FAIL rst_busy d%0d: got %b want 0", d, m_busy[d]); end
      if (m_halted[d] !== 1'b0) begin n_bad++;
        $display("FAIL rst_halted d%0d: got %b want 0", d, m_halted[d]); end
      exp_instr[d] = 32'h0;
      exp_pc[d] = 8'(RPC[d]);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp += 2;
        if (m_valid[d] !== 1'b0) begin n_bad++;
          $display("FAIL idle_valid d%0d c%0d: got %b want 0", d, c, m_valid[d]); end
        if (m_busy[d] !== 1'b0) begin n_bad++;
          $display("FAIL idle_busy d%0d c%0d: got %b want 0", d, c, m_busy[d]); end
      end
    end
  endtask

  task automatic test_basic();
    fill_rom(0, -1);
    rom[0][0] = 32'h0000_0005;
    rom[0][1] = 32'h2000_0003;
    rom[0][2] = 32'hA000_0000;
    run_prog(0, 30, 0, 1'b0, 1'b0, -1, -1);
    n_cmp += 3;
    if (req_log.size() != 3 || req_log[0] != 1 || req_log[1] != 4 || req_log[2] != 7) begin n_bad++;
      $display("FAIL basic_req_cycles: got %p want 1,4,7", req_log); end
    if (first_valid != 3) begin n_bad++; $display("FAIL basic_first_valid: got %0d want 3", first_valid); end
    if (m_halted[0] !== 1'b1 || m_pc[0] !== 8'd2) begin n_bad++;
      $display("FAIL basic_halt: got halted=%b pc=%0h want halted=1 pc=2", m_halted[0], m_pc[0]); end
  endtask

  task automatic test_stall();
    run_prog(0, 40, 0, 1'b1, 1'b0, 3, 7);
    n_cmp++;
    if (req_log.size() != 3 || req_log[1] != 9) begin n_bad++;
      $display("FAIL stall_next_req: got %p want 1,9,12", req_log); end
  endtask

  task automatic test_wrap();
    fill_rom(1, -1);
    run_prog(1, 20, 0, 1'b0, 1'b0, -1, -1);
    n_cmp++;
    if (addr_log.size() < 5) begin n_bad++;
      $display("FAIL wrap_count: got %0d fetches want 5", addr_log.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (addr_log[i] !== 8'((RPC[1] + i) % 4)) begin n_bad++;
          $display("FAIL wrap_addr[%0d]: got %0h want %0h", i, addr_log[i], (RPC[1] + i) % 4); end
      end
    end
    do_reset();
  endtask

  task automatic test_latency4();
    fill_rom(2, 6);
    run_prog(2, 300, 30, 1'b0, 1'b1, -1, -1);
    n_cmp += 3;
    if (req_log.size() == 0 || req_log[0] != 1) begin n_bad++;
      $display("FAIL lat4_first_req: got %p want first 1", req_log); end
    if (first_valid != 6) begin n_bad++; $display("FAIL lat4_first_valid: got %0d want 6", first_valid); end
    if (m_pc[2] !== 8'(RPC[2] + 6)) begin n_bad++;
      $display("FAIL lat4_halt_pc: got %0h want %0h", m_pc[2], RPC[2] + 6); end
  endtask

  task automatic test_restart();
    fill_rom(2, 2);
    run_prog(2, 200, 20, 1'b1, 1'b1, -1, -1);
    n_cmp++;
    if (addr_log.size() == 0 || addr_log[0] !== 8'(RPC[2])) begin n_bad++;
      $display("FAIL restart_addr: got %p want first %0h", addr_log, RPC[2]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 9; it++) begin
      do_reset();
      fill_rom(it % 3, (it % 4 == 3) ? -1 : int'($urandom_range(0, 7)));
      run_prog(it % 3, 150, int'($urandom_range(0, 70)), 1'b0, 1'b1, -1, -1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_d[d] = 1'b0;
      stall_d[d] = 1'b0;
    end
    test_reset(1'b0);
    test_basic();
    test_stall();
    test_wrap();
    test_latency4();
    test_restart();
    test_reset(1'b1);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
